// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding a UART frame serializer (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// Latency: a push shows in count after one edge; the start bit begins on the edge after the pop.
// Backpressure: none; pushes while full are dropped and latched in the sticky overflow flag.
module uart_tx_buffered #(
    parameter  int CLK_HZ     = 27000000,
    parameter  int BAUD       = 115200,
    parameter  int FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        cpu_resetn,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic [AW:0] count,
    output logic        busy,
    output logic        overflow,
    output logic        uart_tx
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      shreg, shreg_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic            tx_n;
    logic            push, pop, bit_done;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_n;
`endif

    assign full     = (count == DEPTH_CNT);
    assign push     = wr_en && !full;
    assign pop      = (state == S_IDLE) && (count != '0);
    assign busy     = (count != '0) || (state != S_IDLE);
    assign bit_done = (bcnt == BCNT_LAST);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bcnt_n    = bcnt;
        bit_idx_n = bit_idx;
`ifdef UART_TX_PARITY_EN
        par_n     = par_q;
`endif
        case (state)
            S_IDLE: begin
                if (pop) begin
                    shreg_n = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    par_n   = ^mem[rd_ptr];
`endif
                    bcnt_n  = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                bcnt_n = bcnt + BW'(1);
                if (bit_done) begin
                    bcnt_n    = '0;
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                bcnt_n = bcnt + BW'(1);
                if (bit_done) begin
                    bcnt_n    = '0;
                    shreg_n   = {1'b0, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                bcnt_n = bcnt + BW'(1);
                if (bit_done) begin
                    bcnt_n  = '0;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                bcnt_n = bcnt + BW'(1);
                if (bit_done) begin
                    bcnt_n  = '0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Line level is decoded from the next state so uart_tx can be a plain register.
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_n = par_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bcnt     <= '0;
            bit_idx  <= '0;
            uart_tx  <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bcnt     <= bcnt_n;
            bit_idx  <= bit_idx_n;
            uart_tx  <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_n;
`endif
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= overflow | (wr_en && full);
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a line monitor decodes frames mid-bit and matches them against
// a queue of bytes the stimulus expects to be sent.
module tb_uart_tx_buffered;

    localparam int CPB = 234;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       cpu_resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, busy, overflow, uart_tx;
    logic [4:0] count;

    uart_tx_buffered #(.CLK_HZ(27000000), .BAUD(115200), .FIFO_DEPTH(16)) dut (
        .clk(clk), .cpu_resetn(cpu_resetn), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .count(count), .busy(busy), .overflow(overflow), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gen = 0;
    int frames = 0;
    bit mon_busy = 1'b0;
    logic last_par = 1'b0;
    logic [7:0] sb[$];
    int starts[$];

    int mon_g;
    logic [7:0] mon_b, mon_exp;
    logic mon_p;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: sample mid-bit on the falling clock edge; frames cut short by reset are discarded.
    initial begin : monitor
        mon_p = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_g = gen;
                starts.push_back(cyc);
                repeat (CPB/2) @(negedge clk);
                if (mon_g == gen) begin
                    total++;
                    if (uart_tx !== 1'b0) begin bad++; $display("FAIL start_bit: uart_tx=%b want 0 (cyc %0d)", uart_tx, cyc); end
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                mon_p = uart_tx;
`endif
                repeat (CPB) @(negedge clk);
                if (mon_g == gen) begin
                    total++;
                    if (uart_tx !== 1'b1) begin bad++; $display("FAIL stop_bit: uart_tx=%b want 1 (cyc %0d)", uart_tx, cyc); end
                    total++;
                    if (sb.size() == 0) begin
                        bad++; $display("FAIL frame_unexpected: got %h want no frame", mon_b);
                    end else begin
                        mon_exp = sb.pop_front();
                        if (mon_b !== mon_exp) begin bad++; $display("FAIL frame_data: got %h want %h", mon_b, mon_exp); end
`ifdef UART_TX_PARITY_EN
                        total++;
                        if (mon_p !== ^mon_exp) begin bad++; $display("FAIL parity_bit: got %b want %b for %h", mon_p, ^mon_exp, mon_exp); end
                        last_par = mon_p;
`endif
                    end
                    frames++;
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        wr_en = 1'b1;
        wr_data = b;
        if (accept) sb.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames < target && n < budget) begin tick(); n++; end
        total++;
        if (frames < target) begin bad++; $display("FAIL %s_timeout: frames=%0d want %0d", name, frames, target); end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy !== 1'b0 || mon_busy) && n < budget) begin tick(); n++; end
        total++;
        if (busy !== 1'b0 || mon_busy) begin bad++; $display("FAIL %s_idle_timeout: busy=%b monitor=%b want idle", name, busy, mon_busy); end
    endtask

    task automatic do_reset();
        cpu_resetn = 1'b0;
        gen++;
        sb.delete();
        tick(); tick();
        cpu_resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        cpu_resetn = 1'b0;
        repeat (3) tick();
        total++; if (uart_tx !== 1'b1)  begin bad++; $display("FAIL rst_uart_tx: got %b want 1", uart_tx); end
        total++; if (count !== 5'd0)    begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
        total++; if (full !== 1'b0)     begin bad++; $display("FAIL rst_full: got %b want 0", full); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        cpu_resetn = 1'b1;
        repeat (2) tick();
        total++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL post_rst_idle: uart_tx=%b busy=%b want 1 0", uart_tx, busy); end
    endtask

    task automatic test_single();
        int n = 0;
        int f0 = frames;
        push(8'h41, 1'b1);
        total++; if (count !== 5'd1)   begin bad++; $display("FAIL single_count_after_push: got %0d want 1", count); end
        total++; if (busy !== 1'b1)    begin bad++; $display("FAIL single_busy_after_push: got %b want 1", busy); end
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL single_tx_before_pop: got %b want 1", uart_tx); end
        tick();
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL single_start_edge: got %b want 0", uart_tx); end
        total++; if (count !== 5'd0)   begin bad++; $display("FAIL single_count_after_pop: got %0d want 0", count); end
        while (busy === 1'b1 && n < 5000) begin tick(); n++; end
        total++; if (n != FRAME) begin bad++; $display("FAIL single_busy_len: got %0d want %0d", n, FRAME); end
        wait_frames(f0 + 1, 400, "single");
    endtask

    task automatic test_back_to_back();
        int f0 = frames;
        int si = starts.size();
        logic [4:0] pk = 5'd0;
        push(8'h48, 1'b1); if (count > pk) pk = count;
        push(8'h69, 1'b1); if (count > pk) pk = count;
        push(8'h0A, 1'b1); if (count > pk) pk = count;
        repeat (3) begin tick(); if (count > pk) pk = count; end
        total++; if (pk !== 5'd2) begin bad++; $display("FAIL b2b_count_peak: got %0d want 2", pk); end
        wait_frames(f0 + 3, 3 * (FRAME + 1) + 600, "b2b");
        for (int k = 1; k < 3; k++) begin
            total++;
            if (starts.size() < si + 3) begin
                bad++; $display("FAIL b2b_spacing_%0d: starts=%0d want %0d", k, starts.size() - si, 3);
            end else if (starts[si+k] - starts[si+k-1] != FRAME + 1) begin
                bad++; $display("FAIL b2b_spacing_%0d: got %0d want %0d", k, starts[si+k] - starts[si+k-1], FRAME + 1);
            end
        end
    endtask

    task automatic test_fill();
        int f0;
        wait_idle(5000, "fill_pre");
        f0 = frames;
        for (int i = 0; i < 17; i++) push(8'(i), 1'b1);
        total++; if (count !== 5'd16)   begin bad++; $display("FAIL fill_count: got %0d want 16", count); end
        total++; if (full !== 1'b1)     begin bad++; $display("FAIL fill_full: got %b want 1", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_overflow: got %b want 0", overflow); end
        push(8'hEE, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow: got %b want 1", overflow); end
        total++; if (count !== 5'd16)   begin bad++; $display("FAIL fill_count_after_drop: got %0d want 16", count); end
        wait_frames(f0 + 17, 17 * (FRAME + 1) + 600, "fill");
        wait_idle(3000, "fill_post");
        total++; if (sb.size() != 0 || count !== 5'd0) begin bad++; $display("FAIL fill_drained: queue=%0d count=%0d want 0 0", sb.size(), count); end
    endtask

    task automatic test_drop_on_pop();
        int c1, s, f0;
        do_reset();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pop_drop_rst_overflow: got %b want 0", overflow); end
        f0 = frames;
        push(8'h20, 1'b1);
        c1 = cyc;
        for (int i = 1; i < 17; i++) push(8'h20 + 8'(i), 1'b1);
        s = c1 + 1;
        while (cyc < s + FRAME) tick();
        total++; if (full !== 1'b1) begin bad++; $display("FAIL pop_drop_full_before: got %b want 1", full); end
        push(8'hEE, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL pop_drop_overflow: got %b want 1", overflow); end
        total++; if (count !== 5'd15)   begin bad++; $display("FAIL pop_drop_count: got %0d want 15", count); end
        total++; if (full !== 1'b0)     begin bad++; $display("FAIL pop_drop_full_after: got %b want 0", full); end
        wait_frames(f0 + 1, 10, "pop_drop");
    endtask

    task automatic test_reset_midframe();
        int s, mid, f0;
        bit low_seen = 1'b0;
        do_reset();
        wait_idle(5000, "midrst_pre");
        f0 = frames;
        push(8'h55, 1'b1);
        s = cyc + 1;
        mid = s + 4 * CPB + CPB / 2;
        while (cyc < mid) tick();
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL midrst_bit3: got %b want 0", uart_tx); end
        cpu_resetn = 1'b0;
        gen++;
        sb.delete();
        #1;
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL midrst_tx: got %b want 1", uart_tx); end
        total++; if (count !== 5'd0)   begin bad++; $display("FAIL midrst_count: got %0d want 0", count); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        tick();
        cpu_resetn = 1'b1;
        for (int i = 0; i < FRAME + 200; i++) begin
            tick();
            if (uart_tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
        end
        total++; if (low_seen) begin bad++; $display("FAIL midrst_residual: line activity=1 want 0"); end
        total++; if (frames != f0) begin bad++; $display("FAIL midrst_frames: got %0d want %0d", frames, f0); end
        push(8'hA3, 1'b1);
        wait_frames(f0 + 1, FRAME + 600, "midrst_clean");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int f0;
        wait_idle(5000, "par_pre");
        f0 = frames;
        push(8'h07, 1'b1);
        wait_frames(f0 + 1, FRAME + 600, "par07");
        total++; if (last_par !== 1'b1) begin bad++; $display("FAIL parity_07: got %b want 1", last_par); end
        push(8'h03, 1'b1);
        wait_frames(f0 + 2, FRAME + 600, "par03");
        total++; if (last_par !== 1'b0) begin bad++; $display("FAIL parity_03: got %b want 0", last_par); end
    endtask
`endif

    initial begin : watchdog
        #(95000 * 10);
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_drop_on_pop();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
